uart_transmitter: RTL and testbench

8N1 UART transmitter paired with the existing CNC-side UART receiver, so the FPGA can return status and acknowledge bytes to the host. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first on `tx`. Bit timing uses the same 16x oversampling tick scheme as the receiver, so both ends match at a shared baud rate.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/uart_transmitter.sv | 143 ++++++++++++++
 tb/tb_uart_transmitter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the CNC-side receiver and this transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    localparam int OVERSAMPLE       = 16;
    localparam int DEFAULT_TICK_DIV = 326;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes ahead of the UART serialiser.
// Head data is combinational from storage so it is valid the cycle it is popped.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DW      = 8,
    parameter int FIFO_AW = 2
) (
    input  logic               clk_50MHz,
    input  logic               reset,
    input  logic               push_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic               pop_i,
    output logic [DW-1:0]      rdata_o,
    output logic               full_o,
    output logic [FIFO_AW:0]   count_o
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

    logic [DW-1:0]      mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               empty;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk_50MHz) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: valid/ready byte intake into a FIFO, 16x tick-timed
// serialiser with registered line output, matched to the CNC-side receiver.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DBITS    = 8,
    parameter int SB_TICK  = 16,
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int FIFO_AW  = 2
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic [DBITS-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [4:0]       OS_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]       SB_LAST  = 5'(SB_TICK - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DBITS - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             sample_tick;

    assign sample_tick = (div_q == DIV_LAST);
    assign div_d       = sample_tick ? '0 : div_q + 1'b1;

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    uart_state_e      state_q;
    logic [4:0]       tcnt_q;
    logic [2:0]       ncnt_q;
    logic [DBITS-1:0] shift_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    logic             fifo_pop;
    logic             fifo_full;
    logic [DBITS-1:0] fifo_head;
    logic [FIFO_AW:0] fifo_count;

    // Only the IDLE->START transition consumes the head byte, so frames start on a tick.
    assign fifo_pop = (state_q == IDLE) && sample_tick && (fifo_count != '0);
    assign tx_ready = !fifo_full;

    uart_tx_fifo #(
        .DW      (DBITS),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .push_i    (tx_valid),
        .wdata_i   (tx_data),
        .pop_i     (fifo_pop),
        .rdata_o   (fifo_head),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            ncnt_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: done_q defaults low every clock so it can only pulse on the STOP->IDLE edge.
            done_q <= 1'b0;
            busy_q <= (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (fifo_pop) begin
                        shift_q <= fifo_head;
                        tcnt_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (sample_tick) begin
                        if (tcnt_q == OS_LAST) begin
                            tcnt_q  <= '0;
                            ncnt_q  <= '0;
                            state_q <= DATA;
                        end else begin
                            tcnt_q <= tcnt_q + 5'd1;
                        end
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (sample_tick) begin
                        if (tcnt_q == OS_LAST) begin
                            tcnt_q  <= '0;
                            shift_q <= shift_q >> 1;
                            if (ncnt_q == BIT_LAST) begin
                                state_q <= STOP;
                            end else begin
                                ncnt_q <= ncnt_q + 3'd1;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + 5'd1;
                        end
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (sample_tick) begin
                        if (tcnt_q == SB_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            tcnt_q <= tcnt_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a line decoder checks every clock of every frame
// against the byte queue accepted over the handshake.
module tb_uart_transmitter;

    localparam int TICK_DIV     = 4;
    localparam int BIT_CLKS     = 16 * TICK_DIV;
    localparam int FRAME_CLKS   = 10 * BIT_CLKS;
    localparam int READY_BUDGET = 2 * FRAME_CLKS;
    localparam int WATCHDOG_CLK = 90000;

    logic       clk_50MHz = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;

    always #10 clk_50MHz = ~clk_50MHz;

    uart_transmitter #(
        .DBITS    (8),
        .SB_TICK  (16),
        .TICK_DIV (TICK_DIV),
        .FIFO_AW  (2)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    int         done_count   = 0;
    bit         mon_en       = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_bytes[$];
    int         frame_start[$];

    always @(posedge clk_50MHz) cyc <= cyc + 1;
    always @(negedge clk_50MHz) if (tx_done === 1'b1) done_count <= done_count + 1;

    // Decoder: from the first low clock, the line must hold each of the 10 bits for
    // BIT_CLKS clocks, with tx_done high only on the last clock of the stop bit.
    initial begin : line_monitor
        forever begin
            @(negedge clk_50MHz);
            if (mon_en && tx === 1'b0) begin
                logic [9:0] frame;
                logic [7:0] got;
                int         t0;
                int         bad_k;
                bit         done_ok;
                bit         unexpected;
                t0         = cyc;
                bad_k      = -1;
                done_ok    = 1'b1;
                got        = 8'h00;
                unexpected = (exp_q.size() == 0);
                frame      = {1'b1, (unexpected ? 8'h00 : exp_q[0]), 1'b0};
                for (int k = 0; k < FRAME_CLKS; k++) begin
                    if (k > 0) @(negedge clk_50MHz);
                    if (tx !== frame[k / BIT_CLKS] && bad_k < 0) bad_k = k;
                    if (tx_done !== (k == FRAME_CLKS - 1)) done_ok = 1'b0;
                    if (k % BIT_CLKS == BIT_CLKS / 2 && k / BIT_CLKS >= 1 && k / BIT_CLKS <= 8)
                        got[k / BIT_CLKS - 1] = tx;
                end
                tests_run++;
                if (unexpected || bad_k >= 0 || got !== frame[8:1]) begin
                    tests_failed++;
                    $display("FAIL line_frame: start at cycle %0d decoded 0x%02h, first bad clock %0d, unexpected=%0b (required 0x%02h with %0d-clock bits)",
                             t0, got, bad_k, unexpected, frame[8:1], BIT_CLKS);
                end
                tests_run++;
                if (!done_ok) begin
                    tests_failed++;
                    $display("FAIL tx_done_timing: frame at cycle %0d had tx_done off-position (required one pulse at frame clock %0d)",
                             t0, FRAME_CLKS - 1);
                end
                if (!unexpected) exp_q.delete(0);
                rx_bytes.push_back(got);
                frame_start.push_back(t0);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, output int waited);
        waited   = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && waited < READY_BUDGET) begin
            @(negedge clk_50MHz);
            waited++;
        end
        if (tx_ready === 1'b1) begin
            exp_q.push_back(b);
            @(negedge clk_50MHz);
        end else begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: tx_ready=%b after %0d clocks (required 1)", tx_ready, waited);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0) && n < budget) begin
            @(negedge clk_50MHz);
            n++;
        end
        tests_run++;
        if (n >= budget) begin
            tests_failed++;
            $display("FAIL drain_timeout: %0d bytes still pending, busy=%b (required 0 pending, busy 0)", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(negedge clk_50MHz);
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: tx=%b (required 1)", tx); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: busy=%b (required 0)", busy); end
        tests_run++;
        if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: tx_ready=%b (required 1)", tx_ready); end
        tests_run++;
        if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: tx_done=%b (required 0)", tx_done); end
        reset = 1'b0;
        bad   = 0;
        repeat (FRAME_CLKS) begin
            @(negedge clk_50MHz);
            if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: %0d clocks left idle (required 0)", bad);
        end
    endtask

    task automatic test_single_frame();
        int w, d0;
        d0 = done_count;
        push_byte(8'h55, w);
        tx_valid = 1'b0;
        wait_drain(3 * FRAME_CLKS);
        tests_run++;
        if (done_count - d0 != 1) begin
            tests_failed++;
            $display("FAIL single_done_count: %0d pulses (required 1)", done_count - d0);
        end
        tests_run++;
        if (rx_bytes.size() == 0 || rx_bytes[$] !== 8'h55) begin
            tests_failed++;
            $display("FAIL single_rx: %0d bytes decoded, last 0x%02h (required 0x55)",
                     rx_bytes.size(), (rx_bytes.size() == 0) ? 8'h00 : rx_bytes[$]);
        end
    endtask

    task automatic test_back_to_back();
        int w, d0, n0, gap;
        d0 = done_count;
        n0 = frame_start.size();
        push_byte(8'hA3, w);
        push_byte(8'h0F, w);
        tx_valid = 1'b0;
        wait_drain(4 * FRAME_CLKS);
        tests_run++;
        if (done_count - d0 != 2) begin
            tests_failed++;
            $display("FAIL b2b_done_count: %0d pulses (required 2)", done_count - d0);
        end
        gap = (frame_start.size() == n0 + 2) ? frame_start[n0 + 1] - frame_start[n0] - FRAME_CLKS : -1;
        tests_run++;
        if (gap != TICK_DIV) begin
            tests_failed++;
            $display("FAIL b2b_gap: idle gap %0d clocks (required %0d)", gap, TICK_DIV);
        end
        tests_run++;
        if (rx_bytes.size() < 2 || rx_bytes[rx_bytes.size() - 2] !== 8'hA3 || rx_bytes[$] !== 8'h0F) begin
            tests_failed++;
            $display("FAIL b2b_rx: decoded bytes out of order or missing (required 0xa3 then 0x0f)");
        end
    endtask

    task automatic test_fifo_full();
        int  w, waits, d0, t;
        bit  ok;
        d0 = done_count;
        push_byte(8'h01, w);
        tx_valid = 1'b0;
        t = 0;
        while (busy !== 1'b1 && t < 2 * TICK_DIV + 2) begin
            @(negedge clk_50MHz);
            t++;
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_after_pop: busy=%b (required 1 within one tick)", busy);
        end
        waits = 0;
        for (int i = 2; i <= 5; i++) begin
            push_byte(8'(i), w);
            waits += w;
        end
        tests_run++;
        if (waits != 0 || tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_drop: %0d stall clocks, tx_ready=%b after 0x05 (required 0 stalls, tx_ready 0)", waits, tx_ready);
        end
        tx_data = 8'h06;
        t = 0;
        while (tx_ready !== 1'b1 && t < READY_BUDGET) begin
            @(negedge clk_50MHz);
            t++;
        end
        tests_run++;
        if (tx_ready !== 1'b1 || tx !== 1'b1 || done_count - d0 != 1) begin
            tests_failed++;
            $display("FAIL ready_rise: tx_ready=%b tx=%b frames done %0d (required 1, 1, 1)", tx_ready, tx, done_count - d0);
        end
        exp_q.push_back(8'h06);
        @(negedge clk_50MHz);
        tx_valid = 1'b0;
        tests_run++;
        if (tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL pop_alignment: tx=%b the clock after tx_ready rose (required 0, start of 0x02)", tx);
        end
        wait_drain(6 * FRAME_CLKS);
        tests_run++;
        if (done_count - d0 != 6) begin
            tests_failed++;
            $display("FAIL full_done_count: %0d pulses (required 6)", done_count - d0);
        end
        ok = (rx_bytes.size() >= 6);
        for (int i = 0; i < 6; i++)
            if (ok && rx_bytes[rx_bytes.size() - 6 + i] !== 8'(i + 1)) ok = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL full_rx_order: decoded bytes differ (required 0x01..0x06 in order)");
        end
    endtask

    task automatic reset_during_frame(input logic [7:0] b, input int k_off);
        int         w, t, bad;
        logic [9:0] frame;
        mon_en = 1'b0;
        frame  = {1'b1, b, 1'b0};
        push_byte(b, w);
        push_byte(8'h11, w);
        push_byte(8'h22, w);
        tx_valid = 1'b0;
        t = 0;
        while (tx !== 1'b0 && t < READY_BUDGET) begin
            @(negedge clk_50MHz);
            t++;
        end
        repeat (k_off) @(negedge clk_50MHz);
        tests_run++;
        if (tx !== frame[k_off / BIT_CLKS] || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_frame_line: tx=%b busy=%b (required %b, 1)", tx, busy, frame[k_off / BIT_CLKS]);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: tx=%b busy=%b tx_ready=%b tx_done=%b (required 1 0 1 0)", tx, busy, tx_ready, tx_done);
        end
        exp_q.delete();
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b0;
        bad   = 0;
        repeat (2 * FRAME_CLKS) begin
            @(negedge clk_50MHz);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL queue_discarded: %0d non-idle clocks after reset (required 0)", bad);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        reset_during_frame(8'hFF, 4 * BIT_CLKS + 24);
        reset_during_frame(8'h00, 4 * BIT_CLKS + 24);
    endtask

    task automatic test_random_loopback();
        logic [7:0] sent[$];
        int         w, d0, base, gap;
        bit         ok;
        d0   = done_count;
        base = rx_bytes.size();
        sent = '{8'h00, 8'hFF, 8'h5A};
        for (int i = 0; i < 12; i++) sent.push_back(8'($urandom));
        foreach (sent[i]) begin
            push_byte(sent[i], w);
            tx_valid = 1'b0;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 800)) : int'($urandom_range(0, 4));
            repeat (gap) @(negedge clk_50MHz);
        end
        wait_drain(20 * FRAME_CLKS);
        tests_run++;
        if (done_count - d0 != sent.size()) begin
            tests_failed++;
            $display("FAIL loop_done_count: %0d pulses (required %0d)", done_count - d0, sent.size());
        end
        ok = (rx_bytes.size() == base + sent.size());
        foreach (sent[i]) if (ok && rx_bytes[base + i] !== sent[i]) ok = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL loop_rx: %0d bytes decoded (required %0d matching the sent sequence)", rx_bytes.size() - base, sent.size());
        end
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_frame();
        test_random_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        repeat (WATCHDOG_CLK) @(posedge clk_50MHz);
        $display("FAIL watchdog: run exceeded %0d clocks (required completion)", WATCHDOG_CLK);
        $fatal(1, "watchdog expired");
    end

endmodule
